multiplier: RTL and testbench
=============================

MULTIPLIER -- requirements
Module: multiplier

Interface
REQ-001 Parameter DATA_LEN, default 32: operand and result width in bits; legal range 2..64.
REQ-002 Parameter PIPELINE_STAGE, default 2: number of register stages from operand inputs to result output, including the output register; legal range 1..8.
REQ-003 clk  input  1: the block's one clock; all state updates on the rising edge; may be driven by an externally divided clock.
REQ-004 reset  input  1: asynchronous, active-high reset.
REQ-005 a  input  DATA_LEN: unsigned multiplicand.
REQ-006 b  input  DATA_LEN: unsigned multiplier.
REQ-007 result  output  DATA_LEN: registered product; driven only from the final pipeline register.

Function
REQ-008 result SHALL equal the low DATA_LEN bits of the unsigned product a*b; upper DATA_LEN bits are discarded, with no overflow flag.
REQ-009 a and b SHALL be sampled on every rising clk edge; there is no valid/enable handshake.
REQ-010 Operands sampled at edge N SHALL appear on result immediately after edge N+PIPELINE_STAGE-1 and hold until the next edge.
REQ-011 Throughput SHALL be one multiplication per clock; back-to-back operand pairs emerge on result in order, one per cycle.
REQ-012 The pipeline SHALL split the work across stages, e.g. partial-product generation and partial-sum accumulation distributed over PIPELINE_STAGE stages, with the final stage registering the truncated sum; a single-stage combinational multiply followed by a delay line is also acceptable, provided REQ-010 holds.
REQ-013 With PIPELINE_STAGE=1, result SHALL be the product of a and b sampled at the most recent edge.
REQ-014 Operands of 0 SHALL propagate as result 0 after the same latency; idle input of 0 after an operation SHALL therefore flush the pipeline to 0.
REQ-015 The block SHALL contain no state machine and no data-dependent latency; latency is identical for all operand values, including 0, 1 and all-ones.
REQ-016 Changing a or b between edges SHALL have no effect on result until the next edge.

Reset
REQ-017 While reset is high, all pipeline registers and result SHALL be 0, asynchronously, regardless of clk.
REQ-018 Reset asserted mid-operation SHALL discard all in-flight products; no pre-reset product appears on result after reset deassertion.
REQ-019 After reset deasserts, the first valid product SHALL appear per REQ-010, counting from the first rising edge with reset low; earlier cycles output 0 or products of the sampled inputs.

Verification
REQ-020 Defaults, reset, then a=6, b=7 for one cycle, then a=b=0 -> result=42 after the 2nd edge, returning to 0 one cycle later.
REQ-021 a=32'hFFFF_FFFF, b=2 -> result=32'hFFFF_FFFE (truncation); a=b=32'h0001_0000 -> result=0.
REQ-022 Back-to-back stream (3,5), (10,10), (0,9), (1,123) on consecutive edges -> results 15, 100, 0, 123 on consecutive cycles with a fixed latency of PIPELINE_STAGE.
REQ-023 Assert reset asynchronously while (1000,1000) is in flight -> result=0 immediately; after release with inputs 0, result stays 0.
REQ-024 PIPELINE_STAGE=1 and PIPELINE_STAGE=4 with a=12345, b=678 -> result=8369910 after 1 and 4 edges respectively.
REQ-025 DATA_LEN=8, a=8'd20, b=8'd13 -> result=8'd4 (260 mod 256).

Source files
------------

// File: rtl/multiplier.sv
// ============================================================================
// Module   : multiplier
// Purpose  : Pipelined unsigned multiplier returning the low DATA_LEN bits of
//            a*b. Each stage adds one slice of b's partial products.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multiplier #(
    parameter int DATA_LEN       = 32,
    parameter int PIPELINE_STAGE = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DATA_LEN-1:0] a,
    input  logic [DATA_LEN-1:0] b,
    output logic [DATA_LEN-1:0] result
);

    localparam int c_CHUNK_W = (DATA_LEN + PIPELINE_STAGE - 1) / PIPELINE_STAGE;

    function automatic logic [DATA_LEN-1:0] chunk_mask(input int lo, input int hi);
        logic [DATA_LEN-1:0] m;
        m = '0;
        for (int i = 0; i < DATA_LEN; i++) begin
            m[i] = (i >= lo) && (i < hi);
        end
        return m;
    endfunction

    // Inputs seen by each stage: operands and the sum of earlier slices.
    logic [DATA_LEN-1:0] w_a   [PIPELINE_STAGE];
    logic [DATA_LEN-1:0] w_b   [PIPELINE_STAGE];
    logic [DATA_LEN-1:0] w_acc [PIPELINE_STAGE];

    assign w_a[0]   = a;
    assign w_b[0]   = b;
    assign w_acc[0] = '0;

    generate
        for (genvar s = 0; s < PIPELINE_STAGE; s++) begin : g_stage
            localparam int c_LO = s * c_CHUNK_W;
            localparam int c_HI = (c_LO + c_CHUNK_W > DATA_LEN) ? DATA_LEN : c_LO + c_CHUNK_W;
            localparam logic [DATA_LEN-1:0] c_MASK = chunk_mask(c_LO, c_HI);

            logic [DATA_LEN-1:0] w_part;
            logic [DATA_LEN-1:0] r_acc;

            // Slices past DATA_LEN get an empty mask and contribute nothing.
            assign w_part = w_a[s] * (w_b[s] & c_MASK);

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_acc <= '0;
                end else begin
                    r_acc <= w_acc[s] + w_part;
                end
            end

            if (s < PIPELINE_STAGE - 1) begin : g_fwd
                logic [DATA_LEN-1:0] r_a;
                logic [DATA_LEN-1:0] r_b;

                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        r_a <= '0;
                        r_b <= '0;
                    end else begin
                        r_a <= w_a[s];
                        r_b <= w_b[s];
                    end
                end

                assign w_a[s+1]   = r_a;
                assign w_b[s+1]   = r_b;
                assign w_acc[s+1] = r_acc;
            end else begin : g_out
                assign result = r_acc;
            end
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_multiplier.sv
// ============================================================================
// Module   : tb_multiplier
// Purpose  : Self-checking bench for multiplier across several parameter sets.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multiplier;

    logic        clk;
    logic        reset;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res1, res2, res4;
    logic [7:0]  res8;

    int vectors     = 0;
    int miscompares = 0;

    // Operand history: index 0 is the pair sampled at the most recent edge.
    logic [31:0] ha [8];
    logic [31:0] hb [8];

    multiplier #(.DATA_LEN(32), .PIPELINE_STAGE(2)) dut2 (
        .clk(clk), .reset(reset), .a(a), .b(b), .result(res2));
    multiplier #(.DATA_LEN(32), .PIPELINE_STAGE(1)) dut1 (
        .clk(clk), .reset(reset), .a(a), .b(b), .result(res1));
    multiplier #(.DATA_LEN(32), .PIPELINE_STAGE(4)) dut4 (
        .clk(clk), .reset(reset), .a(a), .b(b), .result(res4));
    multiplier #(.DATA_LEN(8), .PIPELINE_STAGE(3)) dut8 (
        .clk(clk), .reset(reset), .a(a[7:0]), .b(b[7:0]), .result(res8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                ha[i] = '0;
                hb[i] = '0;
            end
        end else begin
            for (int i = 7; i > 0; i--) begin
                ha[i] = ha[i-1];
                hb[i] = hb[i-1];
            end
            ha[0] = a;
            hb[0] = b;
        end
    end

    function automatic logic [31:0] exp32(input int lat);
        logic [31:0] p;
        p = ha[lat-1] * hb[lat-1];
        return p;
    endfunction

    function automatic logic [31:0] exp8(input int lat);
        logic [7:0] x, y, p;
        x = ha[lat-1][7:0];
        y = hb[lat-1][7:0];
        p = x * y;
        return {24'd0, p};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model_ps1", res1, exp32(1));
        check("model_ps2", res2, exp32(2));
        check("model_ps4", res4, exp32(4));
        check("model_dl8", {24'd0, res8}, exp8(3));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    logic [31:0] stream_a   [4];
    logic [31:0] stream_b   [4];
    logic [31:0] stream_exp [4];

    initial begin
        stream_a   = '{32'd3, 32'd10, 32'd0, 32'd1};
        stream_b   = '{32'd5, 32'd10, 32'd9, 32'd123};
        stream_exp = '{32'd15, 32'd100, 32'd0, 32'd123};

        reset = 1'b1;
        a = '0;
        b = '0;
        tick();
        check("reset_ps1", res1, 32'd0);
        check("reset_ps2", res2, 32'd0);
        check("reset_ps4", res4, 32'd0);
        check("reset_dl8", {24'd0, res8}, 32'd0);
        tick();
        reset = 1'b0;
        tick();

        a = 32'd6; b = 32'd7;
        tick();
        check("6x7_ps1", res1, 32'd42);
        a = '0; b = '0;
        tick();
        check("6x7_ps2", res2, 32'd42);
        tick();
        check("6x7_flush", res2, 32'd0);

        a = 32'hFFFF_FFFF; b = 32'd2;
        tick();
        check("trunc_ps1", res1, 32'hFFFF_FFFE);
        a = 32'h0001_0000; b = 32'h0001_0000;
        tick();
        check("trunc_ps2", res2, 32'hFFFF_FFFE);
        check("wrap_ps1", res1, 32'd0);
        a = '0; b = '0;
        tick();
        check("wrap_ps2", res2, 32'd0);

        for (int i = 0; i < 6; i++) begin
            a = (i < 4) ? stream_a[i] : 32'd0;
            b = (i < 4) ? stream_b[i] : 32'd0;
            tick();
            if (i >= 1 && i <= 4) check("stream_ps2", res2, stream_exp[i-1]);
        end

        a = 32'd12345; b = 32'd678;
        tick();
        check("12345x678_ps1", res1, 32'd8369910);
        a = '0; b = '0;
        tick();
        tick();
        check("12345x678_ps4_early", res4, 32'd0);
        tick();
        check("12345x678_ps4", res4, 32'd8369910);
        tick();
        check("12345x678_ps4_flush", res4, 32'd0);

        a = 32'd20; b = 32'd13;
        tick();
        a = '0; b = '0;
        tick();
        tick();
        check("20x13_dl8", {24'd0, res8}, 32'd4);

        a = 32'd1000; b = 32'd1000;
        tick();
        a = '0; b = '0;
        tick();
        check("inflight_ps2", res2, 32'd1000000);
        #2 reset = 1'b1;
        #1;
        check("async_rst_ps2", res2, 32'd0);
        check("async_rst_ps4", res4, 32'd0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("post_rst_ps4", res4, 32'd0);
        end

        for (int i = 0; i < 400; i++) begin
            a = pick();
            b = pick();
            if (i == 250) begin
                #3 reset = 1'b1;
                #1;
                check("rand_rst_ps4", res4, 32'd0);
            end
            tick();
            if (i == 250) reset = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
